hazard_sequencer: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W). It keeps its own shadow copy of the register-address and control fields per stage (E, M, W), so the datapath needs no extra pipeline registers for hazard logic. From that copy it drives operand-forwarding selects, load-use stalls, branch flushes and a whole-pipeline freeze while data memory is not ready. It also keeps saturating performance counters for stall, flush and memory-wait cycles.

---
 rtl/hazard_sequencer_pkg.sv | 17 +
 rtl/hazard_fwd_sel.sv | 33 +++
 rtl/hazard_sequencer.sv | 177 +++++++++++++++++
 tb/tb_hazard_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sequencer_pkg.sv
// Purpose : shared constants and types for the 5-stage pipeline hazard controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package hazard_sequencer_pkg;

  // Operand-forwarding select encodings driven to the E-stage ALU muxes.
  localparam logic [1:0] FWD_REG = 2'b00;  // value read from the register file
  localparam logic [1:0] FWD_W   = 2'b01;  // result being written back in W
  localparam logic [1:0] FWD_M   = 2'b10;  // ALU result sitting in M

  // Memory-wait FSM: RUN is normal flow, MEM_WAIT while a data access is pending.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Purpose : forwarding select for one E-stage source operand (M beats W, x0 never forwarded).
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of the shadow fields.
//
// Ports:
//   rs_e        source register of the instruction in E
//   rd_m/rd_w   destination registers of the instructions in M and W
//   regwrite_m/regwrite_w  those instructions write the register file
//   fwd_sel     FWD_REG / FWD_M / FWD_W
module hazard_fwd_sel
  import hazard_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  regwrite_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_w,
  output logic [1:0]            fwd_sel
);

  always_comb begin
    fwd_sel = FWD_REG;
    // M is the younger producer, so it must win over W.
    if (regwrite_m && (rd_m != '0) && (rd_m == rs_e)) begin
      fwd_sel = FWD_M;
    end else if (regwrite_w && (rd_w != '0) && (rd_w == rs_e)) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Purpose : hazard controller for the F/D/E/M/W core: forwarding, load-use stall, branch flush, memory freeze.
// Latency : control outputs combinational (zero cycles); shadow state and counters update on the rising edge.
// Backpressure: dmem_ready low with a memory op in M freezes the whole pipeline, including this shadow copy.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rs1_d, rs2_d, rd_d, regwrite_d, load_d, memop_d   decode-stage instruction fields
//   branch_taken_e, dmem_ready    E-stage branch resolution, M-stage memory completion
//   dmem_req, stall_*, flush_*, forward_*_e, mem_wait  pipeline control
//   stall_cnt, flush_cnt, wait_cnt  saturating performance counters
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  regwrite_d,
  input  logic                  load_d,
  input  logic                  memop_d,
  input  logic                  branch_taken_e,
  input  logic                  dmem_ready,
  output logic                  dmem_req,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  mem_wait,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      wait_cnt
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  load;
    logic                  memop;
  } e_stage_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memop;
  } m_stage_t;

  // W only feeds forwarding; its memory access has already completed, so memop is not kept there.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } w_stage_t;

  e_stage_t e_q;
  m_stage_t m_q;
  w_stage_t w_q;
  state_t   state_q, state_d;

  logic freeze;
  logic lu;
  logic br;

  // Shadow state is already zero under reset; the branch input is the one raw
  // input that reaches the flush outputs, so it is masked to keep outputs quiet.
  assign br     = branch_taken_e & ~rst;
  assign freeze = m_q.memop & ~dmem_ready;
  assign lu     = e_q.load & (e_q.rd != '0) & ((e_q.rd == rs1_d) | (e_q.rd == rs2_d));

  assign dmem_req = m_q.memop;

  // Priority: freeze > branch > load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (freeze) begin
      // E is held, so a taken branch there re-resolves once the freeze lifts.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (br) begin
      // The D instruction is discarded, so any load-use against it is moot.
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_e       (e_q.rs1),
    .rd_m       (m_q.rd),
    .regwrite_m (m_q.regwrite),
    .rd_w       (w_q.rd),
    .regwrite_w (w_q.regwrite),
    .fwd_sel    (forward_a_e)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_e       (e_q.rs2),
    .rd_m       (m_q.rd),
    .regwrite_m (m_q.regwrite),
    .rd_w       (w_q.rd),
    .regwrite_w (w_q.regwrite),
    .fwd_sel    (forward_b_e)
  );

  // Shadow pipeline mirrors the datapath registers, including holding on freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else if (!freeze) begin
      w_q <= '{rd: m_q.rd, regwrite: m_q.regwrite};
      m_q <= '{rd: e_q.rd, regwrite: e_q.regwrite, memop: e_q.memop};
      if (flush_e) begin
        e_q <= '0;
      end else begin
        e_q <= '{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                 regwrite: regwrite_d, load: load_d, memop: memop_d};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_wait = 1'b0;
    case (state_q)
      RUN: begin
        if (freeze) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        mem_wait = 1'b1;
        if (dmem_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (lu && !freeze && !br && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br && !freeze && (flush_cnt != '1))        flush_cnt <= flush_cnt + CNT_W'(1);
      if (freeze && (wait_cnt != '1))                wait_cnt  <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic          regwrite_d = 1'b0, load_d = 1'b0, memop_d = 1'b0;
  logic          branch_taken_e = 1'b0, dmem_ready = 1'b1;
  logic          dmem_req, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_wait;
  logic [1:0]    forward_a_e, forward_b_e;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

  hazard_sequencer #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .rs1_d          (rs1_d),
    .rs2_d          (rs2_d),
    .rd_d           (rd_d),
    .regwrite_d     (regwrite_d),
    .load_d         (load_d),
    .memop_d        (memop_d),
    .branch_taken_e (branch_taken_e),
    .dmem_ready     (dmem_ready),
    .dmem_req       (dmem_req),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .stall_m        (stall_m),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .forward_a_e    (forward_a_e),
    .forward_b_e    (forward_b_e),
    .mem_wait       (mem_wait),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .wait_cnt       (wait_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rs1, rs2, rd;
    logic          rw, ld, mo, br, rdy;
    logic [3:0]    stl;   // {stall_f, stall_d, stall_e, stall_m}
    logic [1:0]    fl;    // {flush_d, flush_e}
    logic [1:0]    fa, fb;
    logic          mw, req;
    logic [CW-1:0] sc, fc, wc;
  } vec_t;

  vec_t vecs[22];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t v(int rs1, int rs2, int rd, bit rw, bit ld, bit mo, bit br, bit rdy,
                             int stl, int fl, int fa, int fb, bit mw, bit req,
                             int sc, int fc, int wc);
    vec_t r;
    r.rs1 = RW'(rs1); r.rs2 = RW'(rs2); r.rd = RW'(rd);
    r.rw = rw; r.ld = ld; r.mo = mo; r.br = br; r.rdy = rdy;
    r.stl = 4'(stl); r.fl = 2'(fl); r.fa = 2'(fa); r.fb = 2'(fb);
    r.mw = mw; r.req = req;
    r.sc = CW'(sc); r.fc = CW'(fc); r.wc = CW'(wc);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    rs1_d = x.rs1; rs2_d = x.rs2; rd_d = x.rd;
    regwrite_d = x.rw; load_d = x.ld; memop_d = x.mo;
    branch_taken_e = x.br; dmem_ready = x.rdy;
    exp_q.push_back(x);
  endtask

  task automatic check_front(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      chk($sformatf("v%0d scoreboard_empty", idx), 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("v%0d stalls", idx), {stall_f, stall_d, stall_e, stall_m}, e.stl);
    chk($sformatf("v%0d flushes", idx), {flush_d, flush_e}, e.fl);
    chk($sformatf("v%0d fwd_a", idx), forward_a_e, e.fa);
    chk($sformatf("v%0d fwd_b", idx), forward_b_e, e.fb);
    chk($sformatf("v%0d mem_wait", idx), mem_wait, e.mw);
    chk($sformatf("v%0d dmem_req", idx), dmem_req, e.req);
    chk($sformatf("v%0d stall_cnt", idx), stall_cnt, e.sc);
    chk($sformatf("v%0d flush_cnt", idx), flush_cnt, e.fc);
    chk($sformatf("v%0d wait_cnt", idx), wait_cnt, e.wc);
  endtask

  task automatic set_in(int rs1, int rs2, int rd, bit rw, bit ld, bit mo, bit br, bit rdy);
    rs1_d = RW'(rs1); rs2_d = RW'(rs2); rd_d = RW'(rd);
    regwrite_d = rw; load_d = ld; memop_d = mo;
    branch_taken_e = br; dmem_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                rs1 rs2 rd rw ld mo br rdy | stl  fl fa fb mw req sc fc wc
    // forwarding: add x5, add x6, sub x7 = x5 - x6
    vecs[0]  = v(0, 0, 5, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = v(0, 0, 6, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = v(5, 6, 7, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 2, 0, 0, 0, 0, 0);
    // same shape writing x0 and reading x0: never forwarded
    vecs[4]  = v(0, 0, 0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = v(0, 0, 0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use: lw x7 then add x8 = x0 + x7
    vecs[8]  = v(0, 0, 7, 1, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = v(0, 7, 8, 1, 0, 0, 0, 1,  12, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = v(0, 7, 8, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 1, 0, 0);
    vecs[11] = v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 1, 0, 0);
    // branch in the same cycle as a load-use: branch wins
    vecs[12] = v(0, 0, 9, 1, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[13] = v(9, 0,10, 1, 0, 0, 1, 1,   0, 3, 0, 0, 0, 0, 1, 0, 0);
    vecs[14] = v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 1, 1, 0);
    // store reaching M with memory not ready for 3 cycles
    vecs[15] = v(0, 0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 1, 1, 0);
    vecs[16] = v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 1, 0);
    vecs[17] = v(0, 0, 0, 0, 0, 0, 0, 0,  15, 0, 0, 0, 0, 1, 1, 1, 0);
    vecs[18] = v(0, 0, 0, 0, 0, 0, 1, 0,  15, 0, 0, 0, 1, 1, 1, 1, 1);
    vecs[19] = v(0, 0, 0, 0, 0, 0, 0, 0,  15, 0, 0, 0, 1, 1, 1, 1, 2);
    vecs[20] = v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 1, 1, 1, 3);
    vecs[21] = v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 1, 3);

    // Reset held 3 cycles with random inputs: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      set_in($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      chk($sformatf("reset%0d ctrl", i),
          {dmem_req, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_wait}, 8'd0);
      chk($sformatf("reset%0d fwd", i), {forward_a_e, forward_b_e}, 4'd0);
      chk($sformatf("reset%0d cnt", i), {stall_cnt, flush_cnt, wait_cnt}, 12'd0);
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_front(i);
      next_cycle();
    end

    // Reset asserted in the middle of a freeze.
    set_in(0, 0, 0, 0, 0, 1, 0, 1); next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1); next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("midrst before stalls", {stall_f, stall_d, stall_e, stall_m}, 4'hF);
    rst = 1'b1;
    #1;
    chk("midrst stalls", {stall_f, stall_d, stall_e, stall_m}, 4'h0);
    chk("midrst flush", {flush_d, flush_e}, 2'd0);
    chk("midrst req_wait", {dmem_req, mem_wait}, 2'd0);
    chk("midrst counters", {stall_cnt, flush_cnt, wait_cnt}, 12'd0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;

    // Saturation: lw x7 with rs1=x7 back to back gives a load-use every other cycle.
    for (int k = 1; k <= 40; k++) begin
      set_in(7, 0, 7, 1, 1, 1, 0, 1);
      @(negedge clk);
      chk($sformatf("sat%0d stall_f", k), stall_f, 32'((k % 2) == 0));
      if (k == 29) chk("sat stall_cnt_mid", stall_cnt, 32'd14);
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("sat stall_cnt_final", stall_cnt, 32'd15);
    chk("sat other_cnt", {flush_cnt, wait_cnt}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
